// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: per-channel synchroniser, stability filter,
// clean level and registered rise/fall/long-hold pulses.
module multi_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int TICK_COUNT  = 5000000,
    parameter int SYNC_STAGES = 2,
    parameter int LONG_TICKS  = 50000000
) (
    input  logic                clk_100Mhz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_long
);

    localparam int CW = $clog2(TICK_COUNT + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TICK_COUNT - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_TICKS - 1);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic [CW-1:0]          cnt_r;
        logic [CW-1:0]          cnt_next_s;
        logic [HW-1:0]          hold_r;
        logic [HW-1:0]          hold_next_s;
        logic                   level_r;
        logic                   level_next_s;
        logic                   rise_r;
        logic                   rise_next_s;
        logic                   fall_r;
        logic                   fall_next_s;
        logic                   long_r;
        logic                   long_next_s;
        logic                   samp_s;
        logic                   flip_s;

        assign samp_s = sync_r[SYNC_STAGES-1];
        assign flip_s = (samp_s != level_r) && (cnt_r == C_LAST);

        // Filter and hold-counter next-state; pulses are computed here and registered below.
        always_comb begin
            cnt_next_s   = cnt_r;
            hold_next_s  = hold_r;
            level_next_s = level_r;
            rise_next_s  = 1'b0;
            fall_next_s  = 1'b0;
            long_next_s  = 1'b0;

            // Any return to the stable level restarts the filter.
            if (samp_s == level_r) begin
                cnt_next_s = {CW{1'b0}};
            end else if (flip_s) begin
                cnt_next_s   = {CW{1'b0}};
                level_next_s = samp_s;
                rise_next_s  = samp_s;
                fall_next_s  = ~samp_s;
            end else begin
                cnt_next_s = cnt_r + CW'(1);
            end

            // Hold counter saturates so btn_long fires at most once per press.
            if (!level_r || flip_s) begin
                hold_next_s = {HW{1'b0}};
            end else if (hold_r != H_MAX) begin
                hold_next_s = hold_r + HW'(1);
                long_next_s = (hold_r == H_LAST);
            end else begin
                hold_next_s = hold_r;
            end
        end

        // Channel state and output registers with synchronous reset.
        always_ff @(posedge clk_100Mhz) begin
            if (reset) begin
                sync_r  <= {SYNC_STAGES{1'b0}};
                cnt_r   <= {CW{1'b0}};
                hold_r  <= {HW{1'b0}};
                level_r <= 1'b0;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
                long_r  <= 1'b0;
            end else begin
                sync_r  <= {sync_r[SYNC_STAGES-2:0], btn_in[g]};
                cnt_r   <= cnt_next_s;
                hold_r  <= hold_next_s;
                level_r <= level_next_s;
                rise_r  <= rise_next_s;
                fall_r  <= fall_next_s;
                long_r  <= long_next_s;
            end
        end

        assign btn_level[g] = level_r;
        assign btn_rise[g]  = rise_r;
        assign btn_fall[g]  = fall_r;
        assign btn_long[g]  = long_r;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with TICK_COUNT=4, SYNC_STAGES=2, LONG_TICKS=10.
module tb_multi_debouncer;

    logic       clk_100Mhz;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic [3:0] btn_long;

    int checks;
    int errors;
    int cyc;
    int viol;
    int rise_cnt [4];
    int fall_cnt [4];
    int long_cnt [4];
    int last_rise [4];
    int last_fall [4];
    int last_long [4];

    multi_debouncer #(
        .CHANNELS(4), .TICK_COUNT(4), .SYNC_STAGES(2), .LONG_TICKS(10)
    ) dut (
        .clk_100Mhz(clk_100Mhz),
        .reset(reset),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_long(btn_long)
    );

    initial clk_100Mhz = 1'b0;
    always #5 clk_100Mhz = ~clk_100Mhz;

    task automatic clear_mon();
        for (int c = 0; c < 4; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
            last_rise[c] = -1; last_fall[c] = -1; last_long[c] = -1;
        end
    endtask

    // Advance n cycles, observing outputs at each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100Mhz);
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (btn_rise[c] === 1'b1) begin rise_cnt[c]++; last_rise[c] = cyc; end
                if (btn_fall[c] === 1'b1) begin fall_cnt[c]++; last_fall[c] = cyc; end
                if (btn_long[c] === 1'b1) begin long_cnt[c]++; last_long[c] = cyc; end
            end
            if ((btn_rise & btn_fall) != 4'b0000 || (btn_rise & btn_long) != 4'b0000) viol++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_in = 4'b0000;
        run_cycles(3);
        checks++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 16'h0000) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
        reset = 1'b0;
        run_cycles(2);
        checks++;
        if ({btn_level, btn_rise, btn_fall, btn_long} !== 16'h0000) begin
            errors++; $display("FAIL post_reset_idle: got %h expected 0000", {btn_level, btn_rise, btn_fall, btn_long});
        end
    endtask

    task automatic test_clean_press();
        int t0;
        clear_mon();
        btn_in = 4'b0001; t0 = cyc;
        run_cycles(5);
        checks++;
        if (btn_level !== 4'b0000) begin
            errors++; $display("FAIL press_early: level %b expected 0000", btn_level);
        end
        run_cycles(1);
        checks++;
        if (btn_level !== 4'b0001 || btn_rise !== 4'b0001) begin
            errors++; $display("FAIL press_latency: level %b rise %b expected 0001 0001", btn_level, btn_rise);
        end
        run_cycles(2);
        checks++;
        if (btn_rise !== 4'b0000 || rise_cnt[0] != 1 || btn_level !== 4'b0001) begin
            errors++; $display("FAIL press_single_pulse: rise %b count %0d level %b expected 0000 1 0001", btn_rise, rise_cnt[0], btn_level);
        end
        btn_in = 4'b0000; t0 = cyc;
        run_cycles(8);
        checks++;
        if (fall_cnt[0] != 1 || last_fall[0] - t0 != 6 || btn_level !== 4'b0000) begin
            errors++; $display("FAIL release_latency: falls %0d at %0d level %b expected 1 at 6 0000", fall_cnt[0], last_fall[0] - t0, btn_level);
        end
        checks++;
        if (rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + long_cnt[0] != 0) begin
            errors++; $display("FAIL press_isolation: other pulses %0d expected 0", rise_cnt[1] + rise_cnt[2] + rise_cnt[3] + long_cnt[0]);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pattern;
        int t0;
        pattern = 8'b1111_0111;
        clear_mon();
        t0 = cyc;
        for (int j = 0; j < 8; j++) begin
            btn_in = {2'b00, pattern[j], 1'b0};
            run_cycles(1);
        end
        run_cycles(4);
        checks++;
        if (rise_cnt[1] != 1 || last_rise[1] - t0 != 10) begin
            errors++; $display("FAIL bounce_rise: count %0d at %0d expected 1 at 10", rise_cnt[1], last_rise[1] - t0);
        end
        btn_in = 4'b0000;
        run_cycles(8);
        checks++;
        if (fall_cnt[1] != 1 || long_cnt[1] != 0) begin
            errors++; $display("FAIL bounce_release: falls %0d longs %0d expected 1 0", fall_cnt[1], long_cnt[1]);
        end
    endtask

    task automatic test_long_hold();
        int t0;
        clear_mon();
        btn_in = 4'b0100; t0 = cyc;
        run_cycles(30);
        checks++;
        if (rise_cnt[2] != 1 || last_rise[2] - t0 != 6) begin
            errors++; $display("FAIL long_rise: count %0d at %0d expected 1 at 6", rise_cnt[2], last_rise[2] - t0);
        end
        checks++;
        if (long_cnt[2] != 1 || last_long[2] - last_rise[2] != 10) begin
            errors++; $display("FAIL long_pulse: count %0d offset %0d expected 1 10", long_cnt[2], last_long[2] - last_rise[2]);
        end
        btn_in = 4'b0000;
        run_cycles(8);
        checks++;
        if (fall_cnt[2] != 1 || long_cnt[2] != 1) begin
            errors++; $display("FAIL long_release: falls %0d longs %0d expected 1 1", fall_cnt[2], long_cnt[2]);
        end
        clear_mon();
        btn_in = 4'b0100;
        run_cycles(8);
        btn_in = 4'b0000;
        run_cycles(10);
        checks++;
        if (rise_cnt[2] != 1 || fall_cnt[2] != 1 || long_cnt[2] != 0) begin
            errors++; $display("FAIL short_press: rise %0d fall %0d long %0d expected 1 1 0", rise_cnt[2], fall_cnt[2], long_cnt[2]);
        end
    endtask

    task automatic test_concurrency();
        int t0;
        clear_mon();
        btn_in = 4'b1001; t0 = cyc;
        run_cycles(8);
        checks++;
        if (rise_cnt[0] != 1 || rise_cnt[3] != 1 || last_rise[0] - t0 != 6 || last_rise[3] - t0 != 6) begin
            errors++; $display("FAIL concurrent_rise: ch0 %0d@%0d ch3 %0d@%0d expected 1@6 1@6",
                               rise_cnt[0], last_rise[0] - t0, rise_cnt[3], last_rise[3] - t0);
        end
        btn_in = 4'b1000;
        run_cycles(8);
        checks++;
        if (fall_cnt[0] != 1 || fall_cnt[3] != 0 || btn_level !== 4'b1000) begin
            errors++; $display("FAIL independent_release: fall0 %0d fall3 %0d level %b expected 1 0 1000", fall_cnt[0], fall_cnt[3], btn_level);
        end
        checks++;
        if (long_cnt[3] != 1 || last_long[3] - last_rise[3] != 10 || long_cnt[0] != 0) begin
            errors++; $display("FAIL concurrent_long: long3 %0d offset %0d long0 %0d expected 1 10 0", long_cnt[3], last_long[3] - last_rise[3], long_cnt[0]);
        end
        btn_in = 4'b0000;
        run_cycles(8);
    endtask

    task automatic test_reset_mid();
        int t1;
        clear_mon();
        btn_in = 4'b0010;
        run_cycles(4);
        reset = 1'b1;
        run_cycles(2);
        checks++;
        if (rise_cnt[1] != 0 || {btn_level, btn_rise, btn_fall, btn_long} !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_filter: rises %0d outputs %h expected 0 0000", rise_cnt[1], {btn_level, btn_rise, btn_fall, btn_long});
        end
        reset = 1'b0; t1 = cyc;
        run_cycles(10);
        checks++;
        if (rise_cnt[1] != 1 || last_rise[1] - t1 != 6 || btn_level !== 4'b0010) begin
            errors++; $display("FAIL reset_held_press: count %0d at %0d level %b expected 1 at 6 0010", rise_cnt[1], last_rise[1] - t1, btn_level);
        end
        btn_in = 4'b0000;
        run_cycles(8);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; viol = 0;
        reset = 1'b1; btn_in = 4'b0000;
        clear_mon();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_hold();
        test_concurrency();
        test_reset_mid();
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL pulse_exclusivity: violations %0d expected 0", viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-button debouncer. Each channel synchronises an asynchronous button or key input, filters bounce with a per-channel stability counter, and produces a clean level plus single-cycle press, release and long-hold pulses. It sits between the board buttons and the Morse key/decoder logic; the long-hold pulse gives downstream logic a dot/dash or command threshold without a separate timer.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- TICK_COUNT, 5000000: cycles a synchronised input must differ from the stable level before the level flips (50 ms at 100 MHz); ≥1.
- SYNC_STAGES, 2: synchroniser flop depth per channel (≥2).
- LONG_TICKS, 50000000: cycles the debounced level must stay high before btn_long pulses (500 ms); ≥1.
- clk_100Mhz  input  1  system clock, 100 MHz.
- reset  input  1  reset, synchronous, active-high.
- btn_in  input  CHANNELS  raw asynchronous button inputs, active-high.
- btn_level  output  CHANNELS  debounced stable level.
- btn_rise  output  CHANNELS  one-cycle pulse when btn_level goes 0→1.
- btn_fall  output  CHANNELS  one-cycle pulse when btn_level goes 1→0.
- btn_long  output  CHANNELS  one-cycle pulse, at most once per press, after LONG_TICKS cycles high.

## Operation
- Channels are fully independent; no shared state. Channel i uses only btn_in[i].
- Synchroniser: chain of SYNC_STAGES flops; s = last stage. All stages reset to 0.
- Stability counter C, width $clog2(TICK_COUNT+1), reset 0. Stable level L, reset 0. Per cycle:
  - s == L: C ← 0 (any bounce back restarts the filter).
  - s != L and C == TICK_COUNT-1: L ← s, C ← 0; registered rise (s=1) or fall (s=0) pulse asserted with the new L.
  - otherwise: C ← C+1.
- Hold counter H, width $clog2(LONG_TICKS+1), reset 0:
  - L == 0 or L updating this cycle: H ← 0.
  - L == 1 and H < LONG_TICKS: H ← H+1; when H becomes LONG_TICKS, btn_long pulses that cycle.
  - H == LONG_TICKS: hold (saturate); no further btn_long until a release and a new press.
- All outputs are registered; btn_level = L. Pulses are high exactly one cycle.
- btn_rise and btn_fall are never high together on one channel; btn_long never coincides with btn_rise.
- A release before H reaches LONG_TICKS gives no btn_long.

## Timing
- Reset: all outputs 0 on the cycle after a reset edge; synchroniser, C, L, H cleared. Reset mid-filter or mid-hold discards progress; no pulses emitted due to reset.
- Input held high through reset release: treated as a fresh press; btn_rise fires after the full latency.
- Press/release latency: if btn_in changes and the first edge sampling the new value is edge k, btn_level and the rise/fall pulse update at edge k + SYNC_STAGES + TICK_COUNT − 1, provided the input stays stable.
- Glitch rejection: any excursion of s lasting ≤ TICK_COUNT−1 cycles yields no output change.
- Long hold: btn_long goes high exactly LONG_TICKS cycles after the btn_rise cycle.
- Counter arithmetic never wraps: C is bounded by TICK_COUNT−1 and H saturates at LONG_TICKS.

## Test plan
- Set TICK_COUNT=4, SYNC_STAGES=2, LONG_TICKS=10 and CHANNELS=4 for all scenarios.
- Clean press: drive btn_in[0] 0→1, first sampled at edge k → btn_level[0]=1 and btn_rise[0]=1 for one cycle after edge k+5. The other channels stay 0.
- Bounce: toggle btn_in[1] as 1,1,1,0,1,1,1,1 (one value per cycle) → no rise during the bounce. btn_rise[1] fires once, 5 edges after the final stable-high run starts.
- Long hold vs short: hold ch2 high for 30 cycles → btn_long[2] pulses exactly 10 cycles after btn_rise[2], once only. Then release and press for 8 cycles → btn_fall fires, but no btn_long.
- Concurrency: press ch0 and ch3 on the same cycle → both rise pulses in the same cycle. Release ch0 while ch3 is held → btn_fall[0] only, and ch3 is unaffected.
- Reset mid-operation: assert reset 2 cycles before an expected btn_rise → all outputs 0 and no pulse. After reset, an input still held high gives btn_rise after the full 5-edge latency.
